streaming_fifo_wm: RTL and testbench

Parametrised AXI-Stream FIFO: generic data width and arbitrary (non-power-of-two) depth, occupancy count, almost-full/almost-empty flags and a clearable high-water-mark register. It replaces the fixed-configuration SRL-based stream FIFOs placed between dataflow layers. The high-water mark lets FIFO depth sizing runs read peak occupancy directly instead of sampling `count`.

---
 rtl/streaming_fifo_wm_pkg.sv | 14 +
 rtl/streaming_fifo_wm_if.sv | 11 +
 rtl/streaming_fifo_ram.sv | 25 ++
 rtl/streaming_fifo_wm.sv | 94 +++++++++
 tb/tb_streaming_fifo_wm.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/streaming_fifo_wm_pkg.sv
// Shared helpers for the stream FIFO: pointer wrap and count-width sizing.
package streaming_fifo_pkg;

    // Advance a pointer by one, wrapping from depth-1 back to zero.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/streaming_fifo_wm_if.sv
// AXI-Stream beat channel: data, valid and the reverse ready.
interface streaming_fifo_wm_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] TDATA;
    logic             TVALID;
    logic             TREADY;

    modport master (output TDATA, output TVALID, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/streaming_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read (LUTRAM style).
module streaming_fifo_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/streaming_fifo_wm.sv
// Stream FIFO with arbitrary depth, occupancy flags and a clearable peak-occupancy register.
module streaming_fifo_wm
    import streaming_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1,
    localparam int unsigned CW       = cnt_width(DEPTH)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    streaming_fifo_wm_if.slave    in0_V_V,
    streaming_fifo_wm_if.master   out_V_V,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         max_count,
    input  logic                  wm_clr
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic             out_valid;
    logic             push_c;
    logic             pop_c;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    max_next;
    logic [WIDTH-1:0] rd_data_c;

    // No pass-through when full: ready depends only on the registered count.
    assign in0_V_V.TREADY = !ap_rst && (count != CW'(DEPTH));
    assign out_V_V.TVALID = out_valid;
    assign out_V_V.TDATA  = out_valid ? rd_data_c : '0;

    assign push_c = in0_V_V.TVALID && in0_V_V.TREADY;
    assign pop_c  = out_valid && out_V_V.TREADY;

    streaming_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (ap_clk),
        .we      (push_c),
        .waddr   (wp),
        .wdata   (in0_V_V.TDATA),
        .raddr   (rp),
        .rdata_c (rd_data_c)
    );

    // Next occupancy and watermark; a clear reloads from the post-edge count.
    always_comb begin
        count_next = count;
        max_next   = max_count;
        case ({push_c, pop_c})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        if (wm_clr) begin
            max_next = count_next;
        end else if (count_next > max_count) begin
            max_next = count_next;
        end
    end

    // Flags are registered from count_next so they track count with no added latency.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            max_count    <= '0;
            out_valid    <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (push_c) begin
                wp <= PW'(ptr_inc(32'(wp), DEPTH));
            end
            if (pop_c) begin
                rp <= PW'(ptr_inc(32'(rp), DEPTH));
            end
            count        <= count_next;
            max_count    <= max_next;
            out_valid    <= (count_next != '0);
            almost_full  <= (count_next >= CW'(AF_THRESH));
            almost_empty <= (count_next <= CW'(AE_THRESH));
        end
    end

endmodule

// File: tb/tb_streaming_fifo_wm.sv
// Checks a DEPTH=5 and a default-size FIFO against queue-based reference models.
module tb_streaming_fifo_wm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_rst, s_clr, d_rst, d_clr;
    logic [2:0]  s_count, s_max;
    logic [10:0] d_count, d_max;
    logic s_af, s_ae, d_af, d_ae;

    streaming_fifo_wm_if #(.WIDTH(16)) s_in ();
    streaming_fifo_wm_if #(.WIDTH(16)) s_out ();
    streaming_fifo_wm_if #(.WIDTH(16)) d_in ();
    streaming_fifo_wm_if #(.WIDTH(16)) d_out ();

    streaming_fifo_wm #(.WIDTH(16), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_small (
        .ap_clk(clk), .ap_rst(s_rst), .in0_V_V(s_in), .out_V_V(s_out), .count(s_count),
        .almost_full(s_af), .almost_empty(s_ae), .max_count(s_max), .wm_clr(s_clr));

    streaming_fifo_wm #(.WIDTH(16), .DEPTH(1024)) u_dflt (
        .ap_clk(clk), .ap_rst(d_rst), .in0_V_V(d_in), .out_V_V(d_out), .count(d_count),
        .almost_full(d_af), .almost_empty(d_ae), .max_count(d_max), .wm_clr(d_clr));

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model for the DEPTH=5 instance: queue of beats plus peak occupancy.
    logic [15:0] mq_s[$];
    int mx_s = 0;
    bit mv_s = 0;
    initial begin : cmp_small
        int sz;
        bit push, pop;
        forever begin
            @(negedge clk);
            sz = mq_s.size();
            if (mv_s) begin
                check("s_count", int'(s_count), sz);
                check("s_count_le_depth", int'(s_count <= 3'd5), 1);
                check("s_in_ready", int'(s_in.TREADY), int'(!s_rst && sz != 5));
                check("s_out_valid", int'(s_out.TVALID), int'(sz != 0));
                check("s_out_data", int'(s_out.TDATA), (sz != 0) ? int'(mq_s[0]) : 0);
                check("s_almost_full", int'(s_af), int'(sz >= 4));
                check("s_almost_empty", int'(s_ae), int'(sz <= 1));
                check("s_max_count", int'(s_max), mx_s);
            end
            push = s_in.TVALID && !s_rst && (sz != 5);
            pop  = (sz != 0) && s_out.TREADY;
            if (s_rst) begin
                mq_s.delete();
                mx_s = 0;
                mv_s = 1;
            end else if (mv_s) begin
                if (pop) void'(mq_s.pop_front());
                if (push) mq_s.push_back(s_in.TDATA);
                if (s_clr) mx_s = mq_s.size();
                else if (mq_s.size() > mx_s) mx_s = mq_s.size();
            end
        end
    end

    // Same rules for the default-size instance.
    logic [15:0] mq_d[$];
    int mx_d = 0;
    bit mv_d = 0;
    initial begin : cmp_dflt
        int sz;
        bit push, pop;
        forever begin
            @(negedge clk);
            sz = mq_d.size();
            if (mv_d) begin
                check("d_count", int'(d_count), sz);
                check("d_in_ready", int'(d_in.TREADY), int'(!d_rst && sz != 1024));
                check("d_out_valid", int'(d_out.TVALID), int'(sz != 0));
                check("d_out_data", int'(d_out.TDATA), (sz != 0) ? int'(mq_d[0]) : 0);
                check("d_almost_full", int'(d_af), int'(sz >= 1023));
                check("d_almost_empty", int'(d_ae), int'(sz <= 1));
                check("d_max_count", int'(d_max), mx_d);
            end
            push = d_in.TVALID && !d_rst && (sz != 1024);
            pop  = (sz != 0) && d_out.TREADY;
            if (d_rst) begin
                mq_d.delete();
                mx_d = 0;
                mv_d = 1;
            end else if (mv_d) begin
                if (pop) void'(mq_d.pop_front());
                if (push) mq_d.push_back(d_in.TDATA);
                if (d_clr) mx_d = mq_d.size();
                else if (mq_d.size() > mx_d) mx_d = mq_d.size();
            end
        end
    end

    // One cycle on the small FIFO; reports acceptance and any popped beat.
    task automatic s_cyc(input bit v, input logic [15:0] d, input bit r, input bit clr,
                         output bit acc, output bit pv, output logic [15:0] pd);
        s_in.TVALID  = v;
        s_in.TDATA   = d;
        s_out.TREADY = r;
        s_clr        = clr;
        @(negedge clk);
        acc = v && s_in.TREADY;
        pv  = s_out.TVALID && r;
        pd  = s_out.TDATA;
        @(posedge clk);
        #1;
    endtask

    task automatic s_reset();
        s_rst = 1'b1;
        s_in.TVALID = 1'b0;
        s_out.TREADY = 1'b0;
        s_clr = 1'b0;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit acc, pv;
        logic [15:0] pd;
        logic [15:0] got[$];
        logic [15:0] wdat[23];
        int pushed, popped, guard, idx, dpops;

        s_rst = 1'b1; s_clr = 1'b0; s_in.TVALID = 1'b0; s_in.TDATA = '0; s_out.TREADY = 1'b0;
        d_rst = 1'b1; d_clr = 1'b0; d_in.TVALID = 1'b0; d_in.TDATA = '0; d_out.TREADY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s_rst = 1'b0;
        d_rst = 1'b0;

        check("rst_count", int'(s_count), 0);
        check("rst_valid", int'(s_out.TVALID), 0);
        check("rst_data", int'(s_out.TDATA), 0);
        check("rst_af", int'(s_af), 0);
        check("rst_ae", int'(s_ae), 1);
        check("rst_max", int'(s_max), 0);

        // Fill 1..5 with the consumer stalled.
        for (int i = 1; i <= 5; i++) begin
            s_cyc(1'b1, 16'(i), 1'b0, 1'b0, acc, pv, pd);
            check("fill_acc", int'(acc), 1);
            check("fill_count", int'(s_count), i);
            check("fill_af", int'(s_af), int'(i >= 4));
        end
        check("full_ready", int'(s_in.TREADY), 0);
        repeat (2) begin
            s_cyc(1'b1, 16'h0006, 1'b0, 1'b0, acc, pv, pd);
            check("held_6th", int'(acc), 0);
            check("held_count", int'(s_count), 5);
        end

        // Drain in order.
        got.delete();
        for (int i = 4; i >= 0; i--) begin
            s_cyc(1'b0, 16'h0, 1'b1, 1'b0, acc, pv, pd);
            if (pv) got.push_back(pd);
            check("drain_count", int'(s_count), i);
            check("drain_ae", int'(s_ae), int'(i <= 1));
        end
        check("drain_beats", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) check("drain_data", int'(got[i]), i + 1);

        // Simultaneous push/pop at count 3.
        for (int i = 0; i < 3; i++) s_cyc(1'b1, 16'(16'h11 + i), 1'b0, 1'b0, acc, pv, pd);
        got.delete();
        for (int i = 0; i < 10; i++) begin
            s_cyc(1'b1, 16'(16'h20 + i), 1'b1, 1'b0, acc, pv, pd);
            if (pv) got.push_back(pd);
            check("pp_count", int'(s_count), 3);
        end
        check("pp_beats", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++)
            check("pp_data", int'(got[i]), (i < 3) ? (16'h11 + i) : (16'h20 + i - 3));

        // Full with both sides active: pop only, then balanced.
        s_cyc(1'b1, 16'h002A, 1'b0, 1'b0, acc, pv, pd);
        s_cyc(1'b1, 16'h002B, 1'b0, 1'b0, acc, pv, pd);
        check("full_again", int'(s_count), 5);
        s_cyc(1'b1, 16'h002C, 1'b1, 1'b0, acc, pv, pd);
        check("full_pp_acc", int'(acc), 0);
        check("full_pp_pop", int'(pd), 16'h27);
        check("full_pp_count", int'(s_count), 4);
        s_cyc(1'b1, 16'h002C, 1'b1, 1'b0, acc, pv, pd);
        check("full_pp_acc2", int'(acc), 1);
        check("full_pp_count2", int'(s_count), 4);

        // Watermark: peak 4, clear alongside a push, then regrow.
        s_reset();
        for (int i = 0; i < 4; i++) s_cyc(1'b1, 16'(16'h40 + i), 1'b0, 1'b0, acc, pv, pd);
        for (int i = 0; i < 3; i++) s_cyc(1'b0, 16'h0, 1'b1, 1'b0, acc, pv, pd);
        check("wm_count1", int'(s_count), 1);
        check("wm_peak4", int'(s_max), 4);
        s_cyc(1'b1, 16'h0050, 1'b0, 1'b1, acc, pv, pd);
        check("wm_clr2", int'(s_max), 2);
        s_cyc(1'b1, 16'h0051, 1'b0, 1'b0, acc, pv, pd);
        check("wm_grow3", int'(s_max), 3);
        check("wm_count3", int'(s_count), 3);

        // Reset mid-stream with the producer still pushing.
        s_rst = 1'b1;
        s_in.TVALID = 1'b1;
        s_in.TDATA = 16'hBEEF;
        @(negedge clk);
        check("mid_rst_ready", int'(s_in.TREADY), 0);
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        s_in.TVALID = 1'b0;
        check("mid_rst_count", int'(s_count), 0);
        check("mid_rst_valid", int'(s_out.TVALID), 0);
        check("mid_rst_data", int'(s_out.TDATA), 0);
        check("mid_rst_max", int'(s_max), 0);
        s_cyc(1'b1, 16'hABCD, 1'b0, 1'b0, acc, pv, pd);
        check("post_rst_valid", int'(s_out.TVALID), 1);
        check("post_rst_data", int'(s_out.TDATA), 16'hABCD);

        // 23 random beats with random stalls on both sides across several wraps.
        s_reset();
        for (int i = 0; i < 23; i++) wdat[i] = 16'($urandom);
        pushed = 0; popped = 0; guard = 0;
        while (popped < 23 && guard < 800) begin
            idx = (pushed < 23) ? pushed : 22;
            s_cyc((pushed < 23) && ($urandom_range(0, 2) != 0), wdat[idx],
                  $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, acc, pv, pd);
            if (acc) pushed++;
            if (pv) begin
                check("wrap_order", int'(pd), int'(wdat[popped]));
                popped++;
            end
            guard++;
        end
        check("wrap_done", popped, 23);
        s_in.TVALID = 1'b0;
        s_out.TREADY = 1'b0;
        s_clr = 1'b0;

        // Default size: 3000 beats at full rate, both sides always ready.
        dpops = 0;
        for (int i = 0; i < 3001; i++) begin
            d_in.TVALID = (i < 3000);
            d_in.TDATA = 16'($urandom);
            d_out.TREADY = 1'b1;
            @(negedge clk);
            if (d_out.TVALID) dpops++;
            @(posedge clk);
            #1;
        end
        d_in.TVALID = 1'b0;
        d_out.TREADY = 1'b0;
        check("dflt_pops", dpops, 3000);
        check("dflt_max", int'(d_max), 1);
        check("dflt_count", int'(d_count), 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
